// File: rtl/alu_6502.sv
// alu_6502: registered 8-bit 6502 ALU (clk, sync active-low reset; alu_a, alu_b, mode, carry_in -> alu_out, carry_out, overflow, zero, sign)
module alu_6502 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] mode,
  input  logic       carry_in,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign
);
  logic       arith;
  logic       sub;
  logic [7:0] b;
  logic [8:0] sum;
  logic [7:0] r;
  logic       c;
  logic       v;

  always_comb begin
    sub   = mode == 5'd5;
    arith = sub || mode == 5'd0;
    b     = sub ? ~alu_b : alu_b;
    sum   = {1'b0, alu_a} + {1'b0, b} + {8'd0, carry_in};
    r     = arith          ? sum[7:0] :
            mode == 5'd1   ? alu_a & alu_b :
            mode == 5'd2   ? alu_a | alu_b :
            mode == 5'd3   ? alu_a ^ alu_b :
            mode == 5'd4   ? {carry_in, alu_a[7:1]} :
                             alu_a;
    c     = arith ? sum[8] : mode == 5'd4 ? alu_a[0] : 1'b0;
    v     = arith && (alu_a[7] == b[7]) && (r[7] != alu_a[7]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_out   <= 8'd0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      sign      <= 1'b0;
    end else begin
      alu_out   <= r;
      carry_out <= c;
      overflow  <= v;
      zero      <= r == 8'd0;
      sign      <= r[7];
    end
  end
endmodule

// File: tb/tb_alu_6502.sv
// tb_alu_6502: scoreboard bench for alu_6502, expected {r,c,v,z,n} queued at drive time and compared one cycle later
module tb_alu_6502;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] alu_a = 8'd0;
  logic [7:0] alu_b = 8'd0;
  logic [4:0] mode = 5'd0;
  logic       carry_in = 1'b0;
  logic [7:0] alu_out;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       sign;
  logic [11:0] q[$];
  logic [11:0] obs;
  logic [11:0] exp_v;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [4:0]  m;
    logic        ci;
    logic [11:0] e;
  } vec_t;

  alu_6502 dut (
    .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .mode(mode), .carry_in(carry_in),
    .alu_out(alu_out), .carry_out(carry_out), .overflow(overflow), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  assign obs = {alu_out, carry_out, overflow, zero, sign};

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0; alu_a = 8'hFF; alu_b = 8'h01; mode = 5'd0; carry_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(negedge clk);
        reset = 1'b1;
        q.push_back({8'h00, 4'b1010});
      end else begin
        if (i == 1) @(negedge clk);
        q.push_back(12'h000);
      end
      @(posedge clk); #1;
      exp_v = q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d]: got r=%h c=%b v=%b z=%b n=%b, expected r=%h c=%b v=%b z=%b n=%b",
                 i, obs[11:4], obs[3], obs[2], obs[1], obs[0], exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_vectors(input string name, input vec_t v[6], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      alu_a = v[i].a; alu_b = v[i].b; mode = v[i].m; carry_in = v[i].ci;
      q.push_back(v[i].e);
      @(posedge clk); #1;
      exp_v = q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s[%0d]: got r=%h c=%b v=%b z=%b n=%b, expected r=%h c=%b v=%b z=%b n=%b",
                 name, i, obs[11:4], obs[3], obs[2], obs[1], obs[0], exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_add;
    vec_t v[6];
    v[0] = '{8'h50, 8'h50, 5'd0, 1'b0, {8'hA0, 4'b0101}};
    v[1] = '{8'h7F, 8'h00, 5'd0, 1'b1, {8'h80, 4'b0101}};
    v[2] = '{8'hFF, 8'h01, 5'd0, 1'b0, {8'h00, 4'b1010}};
    v[3] = '{8'h12, 8'h34, 5'd0, 1'b1, {8'h47, 4'b0000}};
    test_vectors("add", v, 4);
  endtask

  task automatic test_sub;
    vec_t v[6];
    v[0] = '{8'h50, 8'h10, 5'd5, 1'b1, {8'h40, 4'b1000}};
    v[1] = '{8'h00, 8'h01, 5'd5, 1'b1, {8'hFF, 4'b0001}};
    v[2] = '{8'h80, 8'h01, 5'd5, 1'b1, {8'h7F, 4'b1100}};
    v[3] = '{8'h05, 8'h05, 5'd5, 1'b0, {8'hFF, 4'b0001}};
    v[4] = '{8'h05, 8'h05, 5'd5, 1'b1, {8'h00, 4'b1010}};
    test_vectors("sub", v, 5);
  endtask

  task automatic test_logic;
    vec_t v[6];
    v[0] = '{8'hF0, 8'h3C, 5'd1, 1'b1, {8'h30, 4'b0000}};
    v[1] = '{8'hF0, 8'h3C, 5'd2, 1'b1, {8'hFC, 4'b0001}};
    v[2] = '{8'hF0, 8'h3C, 5'd3, 1'b1, {8'hCC, 4'b0001}};
    v[3] = '{8'h0F, 8'hF0, 5'd1, 1'b0, {8'h00, 4'b0010}};
    test_vectors("logic", v, 4);
  endtask

  task automatic test_shift;
    vec_t v[6];
    v[0] = '{8'h81, 8'hFF, 5'd4, 1'b0, {8'h40, 4'b1000}};
    v[1] = '{8'h81, 8'h00, 5'd4, 1'b1, {8'hC0, 4'b1001}};
    v[2] = '{8'h01, 8'hFF, 5'd4, 1'b0, {8'h00, 4'b1010}};
    v[3] = '{8'h02, 8'h01, 5'd4, 1'b0, {8'h01, 4'b0000}};
    test_vectors("shift", v, 4);
  endtask

  task automatic test_back_to_back;
    vec_t v[6];
    v[0] = '{8'h10, 8'h20, 5'd0, 1'b0, {8'h30, 4'b0000}};
    v[1] = '{8'h30, 8'h10, 5'd5, 1'b1, {8'h20, 4'b1000}};
    v[2] = '{8'h5A, 8'hFF, 5'd7, 1'b1, {8'h5A, 4'b0000}};
    v[3] = '{8'h00, 8'h01, 5'd31, 1'b1, {8'h00, 4'b0010}};
    v[4] = '{8'h80, 8'h80, 5'd0, 1'b0, {8'h00, 4'b1110}};
    v[5] = '{8'hC3, 8'h3C, 5'd6, 1'b0, {8'hC3, 4'b0001}};
    test_vectors("b2b", v, 6);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_6502.md
# alu_6502

8-bit arithmetic/logic unit for the NES-class 6502-compatible CPU core. It computes add, subtract, bitwise and shift-right results, plus carry, overflow, zero and sign flags. The controller selects the operation from instruction bits. Results are registered, so the controller consumes them one clock after presenting operands.

## Interface
Parameters:
- none; the mode encoding is fixed: ADD=0, AND=1, OR=2, EOR=3, SR=4, SUB=5.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- alu_a  input  8  operand A; the shifted operand for SR.
- alu_b  input  8  operand B; ignored for SR.
- mode  input  5  operation select (encoding above); values 6..31 are reserved.
- carry_in  input  1  carry into ADD/SUB; bit shifted into bit 7 for SR.
- alu_out  output  8  registered result.
- carry_out  output  1  registered carry (6502 sense: 1 = no borrow on SUB).
- overflow  output  1  registered signed overflow.
- zero  output  1  registered, 1 when alu_out == 0x00.
- sign  output  1  registered, equals alu_out[7].

## Operation
Next result R (8 bit) and next carry C are computed combinationally from alu_a, alu_b, mode and carry_in:
- ADD: {C,R} = alu_a + alu_b + carry_in (9-bit sum). V = (a[7]==b[7]) && (R[7]!=a[7]).
- SUB: {C,R} = alu_a + ~alu_b + carry_in (6502 SBC; carry_in=1 means no borrow). V = (a[7]!=b[7]) && (R[7]!=a[7]).
- AND / OR / EOR: R = a&b / a|b / a^b. C=0, V=0.
- SR: R = {carry_in, a[7:1]}; C = a[0]; V=0. LSR uses carry_in=0; ROR uses carry_in = P.C.
- Reserved modes (6..31): R = alu_a, C=0, V=0.
- For all modes: Z = (R==0), N = R[7].
- No decimal (BCD) mode; binary arithmetic only.
- All arithmetic is modulo 256; carry out of bit 7 appears only on carry_out.

## Timing
- On each rising clk with reset=1: alu_out<=R, carry_out<=C, overflow<=V, zero<=Z, sign<=N.
- Latency is exactly 1 cycle from operands/mode to outputs. There is no handshake and no enable; a new operation can start every cycle (throughput 1/cycle).
- On a rising clk with reset=0, all outputs become 0, including zero. The zero output does not reflect the cleared alu_out until the first non-reset cycle.
- Reset dominates. If reset is asserted in the same cycle an operation is presented, that operation is discarded. The first valid result appears one cycle after reset deasserts.
- Outputs hold their last value between edges. Input changes between edges have no effect until the next edge.
- Power-up values before the first reset are undefined.

## Test plan
- Reset: hold reset=0 for 2 cycles with ADD 0xFF+0x01 applied. Required: all outputs 0. Release reset; next cycle: alu_out=0x00, carry_out=1, zero=1, overflow=0.
- ADD signed overflow: 0x50+0x50, ci=0 -> 0xA0, C=0, V=1, N=1, Z=0. Also 0x7F+0x00, ci=1 -> 0x80, V=1.
- SUB: 0x50−0x10, ci=1 -> 0x40, C=1, V=0. 0x00−0x01, ci=1 -> 0xFF, C=0, N=1. 0x80−0x01, ci=1 -> 0x7F, C=1, V=1.
- Logic, a=0xF0 b=0x3C: AND -> 0x30; OR -> 0xFC; EOR -> 0xCC. C=0 and V=0 for all three. AND 0x0F&0xF0 -> 0x00, Z=1.
- SR: a=0x81, ci=0 -> 0x40, C=1. a=0x81, ci=1 -> 0xC0, C=1, N=1. a=0x01, ci=0 -> 0x00, Z=1, C=1.
- Back-to-back and reserved modes: change operands every cycle (ADD, SUB, mode 7 with a=0x5A). Each result must appear exactly one cycle later. Mode 7 -> 0x5A, C=0, V=0.
